// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issuing sequencer: op codes, FSM states
// and the micro-op record that describes one ALU pass.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SLL  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_SLTU = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SR   = 3'd5;
   localparam logic [2:0] OP_OR   = 3'd6;
   localparam logic [2:0] OP_AND  = 3'd7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      P3   = 3'd3,
      RESP = 3'd4
   } seq_state_t;

   // Source for the ALU a input during a pass
   typedef enum logic [1:0] {
      ASEL_A = 2'd0,
      ASEL_B = 2'd1,
      ASEL_T = 2'd2
   } a_sel_t;

   // Source for the ALU b input; b is already shamt-masked for shift ops
   typedef enum logic [1:0] {
      BSEL_B    = 2'd0,
      BSEL_T    = 2'd1,
      BSEL_ONES = 2'd2,
      BSEL_ONE  = 2'd3
   } b_sel_t;

   typedef enum logic {
      DEST_T    = 1'b0,
      DEST_RESP = 1'b1
   } dest_t;

   typedef struct packed {
      logic [2:0] op;
      a_sel_t     a_sel;
      b_sel_t     b_sel;
      dest_t      dest;
   } uop_t;

   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == OP_SLL) || (funct3 == OP_SR);
   endfunction

endpackage

// File: rtl/alu_seq_uop_rom.sv
// Combinational micro-op table: which ALU op and operand sources each pass uses.
// SUB and negative-operand SRA expand to three passes; everything else is one.
module alu_seq_uop_rom
   import alu_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       alt,
   input  logic       a_msb,
   input  logic [1:0] pass,
   output uop_t       uop
);

   always_comb begin
      uop = '{op: funct3, a_sel: ASEL_A, b_sel: BSEL_B, dest: DEST_RESP};
      if (alt && funct3 == OP_ADD) begin
         // a - b = a + (~b + 1), built from XOR and ADD passes
         case (pass)
            2'd0:    uop = '{op: OP_XOR, a_sel: ASEL_B, b_sel: BSEL_ONES, dest: DEST_T};
            2'd1:    uop = '{op: OP_ADD, a_sel: ASEL_T, b_sel: BSEL_ONE,  dest: DEST_T};
            default: uop = '{op: OP_ADD, a_sel: ASEL_A, b_sel: BSEL_T,    dest: DEST_RESP};
         endcase
      end else if (alt && funct3 == OP_SR && a_msb) begin
         // Negative SRA = ~(~a >> shamt), so only a logical shift is needed
         case (pass)
            2'd0:    uop = '{op: OP_XOR, a_sel: ASEL_A, b_sel: BSEL_ONES, dest: DEST_T};
            2'd1:    uop = '{op: OP_SR,  a_sel: ASEL_T, b_sel: BSEL_B,    dest: DEST_T};
            default: uop = '{op: OP_XOR, a_sel: ASEL_T, b_sel: BSEL_ONES, dest: DEST_RESP};
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one integer op per request to an external combinational ALU, chaining
// up to three passes through a temp register, and returns the result on a handshake.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WORD_SIZE-1:0] req_a,
   input  logic [WORD_SIZE-1:0] req_b,
   input  logic [2:0]           req_funct3,
   input  logic                 req_alt,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_SIZE-1:0] resp_data,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   output logic [2:0]           alu_op,
   input  logic [WORD_SIZE-1:0] alu_out,
   output logic                 busy
);

   localparam int SHAMT_W = $clog2(WORD_SIZE);
   localparam logic [WORD_SIZE-1:0] ALL_ONES = {WORD_SIZE{1'b1}};
   localparam logic [WORD_SIZE-1:0] ONE      = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   seq_state_t           state;
   logic [WORD_SIZE-1:0] a_q, b_q, t_q;
   logic [2:0]           funct3_q;
   logic                 alt_q;
   logic [1:0]           pass;
   uop_t                 uop;

   assign pass = (state == P1) ? 2'd0 : (state == P2) ? 2'd1 : 2'd2;

   alu_seq_uop_rom u_rom (
      .funct3 (funct3_q),
      .alt    (alt_q),
      .a_msb  (a_q[WORD_SIZE-1]),
      .pass   (pass),
      .uop    (uop)
   );

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Outside the pass states the ALU sees a harmless ADD of zeros
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = OP_ADD;
      if (state == P1 || state == P2 || state == P3) begin
         alu_op = uop.op;
         case (uop.a_sel)
            ASEL_B:  alu_a = b_q;
            ASEL_T:  alu_a = t_q;
            default: alu_a = a_q;
         endcase
         case (uop.b_sel)
            BSEL_T:    alu_b = t_q;
            BSEL_ONES: alu_b = ALL_ONES;
            BSEL_ONE:  alu_b = ONE;
            default:   alu_b = b_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         t_q        <= '0;
         funct3_q   <= OP_ADD;
         alt_q      <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q      <= req_a;
                  funct3_q <= req_funct3;
                  alt_q    <= req_alt;
                  if (is_shift(req_funct3))
                     b_q <= {{(WORD_SIZE-SHAMT_W){1'b0}}, req_b[SHAMT_W-1:0]};
                  else
                     b_q <= req_b;
                  state <= P1;
               end
            end
            P1, P2, P3: begin
               if (uop.dest == DEST_T) begin
                  t_q   <= alu_out;
                  state <= (state == P1) ? P2 : P3;
               end else begin
                  resp_data  <= alu_out;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU beside the DUT, directed
// vector table, hand-written handshake/reset sequences and random ops vs a reference.
module tb_alu_sequencer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic [2:0]   req_funct3 = '0;
   logic         req_alt = 1'b0;
   logic         resp_valid;
   logic         resp_ready = 1'b0;
   logic [W-1:0] resp_data;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic [2:0]   alu_op;
   logic         busy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WORD_SIZE(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_funct3 (req_funct3),
      .req_alt    (req_alt),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_out    (alu_out),
      .busy       (busy)
   );

   // The ALU that the parent would instantiate beside the sequencer
   function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, b, input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a << b[3:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         3'd3:    return (a < b) ? 16'd1 : 16'd0;
         3'd4:    return a ^ b;
         3'd5:    return a >> b[3:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_out = alu_model(alu_a, alu_b, alu_op);

   // Architectural meaning of each RV-style op
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, b, input logic [2:0] f3, input logic alt);
      int sh;
      sh = int'(b % 16);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << sh;
         3'd2:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         3'd3:    return (a < b) ? 16'd1 : 16'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? W'($signed(a) >>> sh) : a >> sh;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic int ref_passes(input logic [W-1:0] a, input logic [2:0] f3, input logic alt);
      if (alt && f3 == 3'd0) return 3;
      if (alt && f3 == 3'd5 && a[W-1]) return 3;
      return 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Issue one op, return result, cycles to resp_valid, and the alu_op of each pass
   task automatic applyStimulus(input logic [W-1:0] a, b, input logic [2:0] f3, input logic alt,
                                output logic [W-1:0] res, output int lat, output logic [8:0] ops);
      @(negedge clk);
      req_a = a; req_b = b; req_funct3 = f3; req_alt = alt; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom);
      lat = 0; ops = '0;
      while (!resp_valid && lat < 10) begin
         if (lat < 3) ops[lat*3 +: 3] = alu_op;
         @(posedge clk); #1;
         lat++;
      end
      res = resp_data;
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] a, b;
      logic [2:0]   f3;
      logic         alt;
      logic [W-1:0] expected;
      int           passes;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [W-1:0] res, held;
      logic [W-1:0] ra, rb;
      logic [2:0]   rf;
      logic         ralt;
      int           lat;
      logic [8:0]   ops;

      vecs.push_back('{"add_ovf",   16'h7FFF, 16'h0001, 3'd0, 1'b0, 16'h8000, 1});
      vecs.push_back('{"sub_neg",   16'h0000, 16'h0001, 3'd0, 1'b1, 16'hFFFF, 3});
      vecs.push_back('{"sub_zero",  16'h1234, 16'h1234, 3'd0, 1'b1, 16'h0000, 3});
      vecs.push_back('{"sra_neg",   16'h8000, 16'h000F, 3'd5, 1'b1, 16'hFFFF, 3});
      vecs.push_back('{"sra_pos",   16'h4000, 16'h0002, 3'd5, 1'b1, 16'h1000, 1});
      vecs.push_back('{"sll_mask",  16'h0003, 16'h0010, 3'd1, 1'b0, 16'h0003, 1});
      vecs.push_back('{"slt",       16'hFFFF, 16'h0001, 3'd2, 1'b0, 16'h0001, 1});
      vecs.push_back('{"sltu",      16'hFFFF, 16'h0001, 3'd3, 1'b0, 16'h0000, 1});
      vecs.push_back('{"slt_alt",   16'hFFFF, 16'h0001, 3'd2, 1'b1, 16'h0001, 1});
      vecs.push_back('{"srl_mask",  16'hF000, 16'h0014, 3'd5, 1'b0, 16'h0F00, 1});
      vecs.push_back('{"sra_negsh", 16'hF000, 16'h0004, 3'd5, 1'b1, 16'hFF00, 3});
      vecs.push_back('{"and",       16'hF0F0, 16'h3C3C, 3'd7, 1'b0, 16'h3030, 1});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
      @(negedge clk); reset = 1'b0;

      // Plain ADD: check the single pass drive and latency edge by edge
      @(negedge clk);
      req_a = 16'h7FFF; req_b = 16'h0001; req_funct3 = 3'd0; req_alt = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      checkOutput("add_p1_op", 32'(alu_op), 32'd0);
      checkOutput("add_p1_a", 32'(alu_a), 32'h7FFF);
      checkOutput("add_p1_b", 32'(alu_b), 32'h0001);
      checkOutput("add_p1_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("add_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("add_resp_data", 32'(resp_data), 32'h8000);
      checkOutput("add_resp_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      checkOutput("add_done_busy", 32'(busy), 32'd0);

      // Directed table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].alt, res, lat, ops);
         checkOutput({vecs[i].name, "_data"}, 32'(res), 32'(vecs[i].expected));
         checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].passes));
      end

      // SUB pass sequence must be XOR, ADD, ADD
      applyStimulus(16'h0000, 16'h0001, 3'd0, 1'b1, res, lat, ops);
      checkOutput("sub_op_seq", 32'(ops), 32'({3'd0, 3'd0, 3'd4}));

      // Backpressure: response held while consumer stalls, new requests ignored
      @(negedge clk);
      req_a = 16'h00FF; req_b = 16'h0F0F; req_funct3 = 3'd4; req_alt = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_a = 16'hAAAA; req_b = 16'h5555; req_funct3 = 3'd6;
      @(posedge clk); #1;
      held = resp_data;
      checkOutput("bp_data", 32'(held), 32'h0FF0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", 32'(resp_valid), 32'd1);
         checkOutput("bp_data_stable", 32'(resp_data), 32'(held));
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_busy", 32'(busy), 32'd1);
      end
      req_valid = 1'b0;
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      checkOutput("bp_rel_valid", 32'(resp_valid), 32'd0);
      checkOutput("bp_rel_busy", 32'(busy), 32'd0);
      @(negedge clk);
      req_a = 16'h0002; req_b = 16'h0003; req_funct3 = 3'd0; req_alt = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      checkOutput("bp_next_accept", 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput("bp_next_data", 32'(resp_data), 32'h0005);
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;

      // Reset during P2 of a SUB aborts the op
      @(negedge clk);
      req_a = 16'h0010; req_b = 16'h0003; req_funct3 = 3'd0; req_alt = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("rp2_p2_op", 32'(alu_op), 32'd0);
      checkOutput("rp2_p2_b", 32'(alu_b), 32'd1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("rp2_valid", 32'(resp_valid), 32'd0);
      checkOutput("rp2_busy", 32'(busy), 32'd0);
      checkOutput("rp2_data", 32'(resp_data), 32'd0);
      checkOutput("rp2_alu_a", 32'(alu_a), 32'd0);
      checkOutput("rp2_alu_b", 32'(alu_b), 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("rp2_no_resp", 32'(resp_valid), 32'd0);
      end
      applyStimulus(16'h0100, 16'h0011, 3'd6, 1'b0, res, lat, ops);
      checkOutput("rp2_after_data", 32'(res), 32'h0111);
      checkOutput("rp2_after_lat", 32'(lat), 32'd1);

      // Random ops against the architectural reference
      for (int n = 0; n < 200; n++) begin
         ra = W'($urandom); rb = W'($urandom);
         rf = 3'($urandom_range(0, 7)); ralt = 1'($urandom);
         applyStimulus(ra, rb, rf, ralt, res, lat, ops);
         checkOutput("rand_data", 32'(res), 32'(ref_result(ra, rb, rf, ralt)));
         checkOutput("rand_lat", 32'(lat), 32'(ref_passes(ra, rf, ralt)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
